// File: rtl/round_timer.sv
// round_timer: round countdown (binary + BCD) with one-cycle timeout pulse; ROUND_TIMER_WARN_EN adds warn_o.
// Latency: a command sampled at a clock edge takes effect at that edge and shows on outputs the next cycle.
// Backpressure: none; start/pause/abort are sampled every cycle with priority abort > start > pause.
module round_timer #(
  parameter int CLK_FREQ_HZ   = 60_000_000,
  parameter int ROUND_SECONDS = 99
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       abort_i,
  output logic [7:0] seconds_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       running_o,
  output logic       expired_o,
  output logic       timeout_o,
  output logic       warn_o
);

  localparam int            TW        = $clog2(CLK_FREQ_HZ);
  localparam logic [TW-1:0] TICK_MAX  = TW'(CLK_FREQ_HZ - 1);
  localparam logic [7:0]    SEC_INIT  = 8'(ROUND_SECONDS);
  localparam logic [3:0]    TENS_INIT = 4'(ROUND_SECONDS / 10);
  localparam logic [3:0]    ONES_INIT = 4'(ROUND_SECONDS % 10);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    sec_q, sec_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          timeout_q, timeout_d;

  logic active, reload, advance, wrap, last_sec;

  assign active   = (state_q == RUNNING) || (state_q == PAUSED);
  assign reload   = abort_i || start_i;
  // PAUSED with pause_i low advances like RUNNING, so each paused cycle costs exactly one cycle
  assign advance  = active && !reload && !pause_i;
  assign wrap     = advance && (tick_q == TICK_MAX);
  assign last_sec = wrap && (sec_q == 8'd1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else if (start_i) begin
      state_d = RUNNING;
    end else if (active) begin
      if (pause_i) begin
        state_d = PAUSED;
      end else if (last_sec) begin
        state_d = EXPIRED;
      end else begin
        state_d = RUNNING;
      end
    end
  end

  always_comb begin
    tick_d    = tick_q;
    sec_d     = sec_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    timeout_d = 1'b0;
    if (reload) begin
      tick_d = '0;
      sec_d  = SEC_INIT;
      tens_d = TENS_INIT;
      ones_d = ONES_INIT;
    end else if (wrap) begin
      tick_d = '0;
      if (last_sec) begin
        sec_d     = 8'd0;
        tens_d    = 4'd0;
        ones_d    = 4'd0;
        timeout_d = 1'b1;
      end else begin
        sec_d = sec_q - 8'd1;
        if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end else if (advance) begin
      tick_d = tick_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_q    <= '0;
      sec_q     <= SEC_INIT;
      tens_q    <= TENS_INIT;
      ones_q    <= ONES_INIT;
      timeout_q <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      sec_q     <= sec_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    seconds_o = sec_q;
    tens_o    = tens_q;
    ones_o    = ones_q;
    running_o = (state_q == RUNNING);
    expired_o = (state_q == EXPIRED);
    timeout_o = timeout_q;
  end

`ifdef ROUND_TIMER_WARN_EN
  logic warn_q, warn_d;

  assign warn_d = ((state_d == RUNNING) || (state_d == PAUSED)) &&
                  (sec_d != 8'd0) && (sec_d <= 8'd10);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn_o = warn_q;
`else
  assign warn_o = 1'b0;
`endif

endmodule

// File: tb/tb_round_timer.sv
// Bench for round_timer: three instances (3 s, 11 s, 12 s rounds at 10 cycles/s) share one command stream.
module tb_round_timer;

  localparam int F = 10;
`ifdef ROUND_TIMER_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic abort = 1'b0;

  always #5 clk = ~clk;

  logic [7:0] sec_o  [3];
  logic [3:0] tens_o [3];
  logic [3:0] ones_o [3];
  logic       run_o  [3];
  logic       exp_o  [3];
  logic       to_o   [3];
  logic       warn_o [3];

  round_timer #(.CLK_FREQ_HZ(F), .ROUND_SECONDS(3)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pause_i(pause), .abort_i(abort),
    .seconds_o(sec_o[0]), .tens_o(tens_o[0]), .ones_o(ones_o[0]), .running_o(run_o[0]),
    .expired_o(exp_o[0]), .timeout_o(to_o[0]), .warn_o(warn_o[0]));

  round_timer #(.CLK_FREQ_HZ(F), .ROUND_SECONDS(11)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pause_i(pause), .abort_i(abort),
    .seconds_o(sec_o[1]), .tens_o(tens_o[1]), .ones_o(ones_o[1]), .running_o(run_o[1]),
    .expired_o(exp_o[1]), .timeout_o(to_o[1]), .warn_o(warn_o[1]));

  round_timer #(.CLK_FREQ_HZ(F), .ROUND_SECONDS(12)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pause_i(pause), .abort_i(abort),
    .seconds_o(sec_o[2]), .tens_o(tens_o[2]), .ones_o(ones_o[2]), .running_o(run_o[2]),
    .expired_o(exp_o[2]), .timeout_o(to_o[2]), .warn_o(warn_o[2]));

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  function automatic int rsec(input int i);
    return (i == 0) ? 3 : (i == 1) ? 11 : 12;
  endfunction

  // Reference model: a round is a budget of cycles still to run; displayed seconds round up.
  // m_st: 0 idle, 1 running, 2 paused, 3 expired
  int m_rem [3];
  int m_st  [3];
  bit m_to  [3];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_st[i]  <= 0;
        m_rem[i] <= rsec(i) * F;
        m_to[i]  <= 1'b0;
      end else begin
        m_to[i] <= 1'b0;
        if (abort) begin
          m_st[i]  <= 0;
          m_rem[i] <= rsec(i) * F;
        end else if (start) begin
          m_st[i]  <= 1;
          m_rem[i] <= rsec(i) * F;
        end else if (m_st[i] == 1 || m_st[i] == 2) begin
          if (pause) begin
            m_st[i] <= 2;
          end else begin
            m_rem[i] <= m_rem[i] - 1;
            if (m_rem[i] == 1) begin
              m_st[i] <= 3;
              m_to[i] <= 1'b1;
            end else begin
              m_st[i] <= 1;
            end
          end
        end
      end
    end
  end

  function automatic logic [19:0] pk(input int s, input bit r, input bit e, input bit t, input bit w);
    return {8'(s), 4'(s / 10), 4'(s % 10), r, e, t, w & WARN_ON};
  endfunction

  function automatic logic [19:0] model_out(input int i);
    int s;
    bit w;
    s = (m_rem[i] + F - 1) / F;
    w = (m_st[i] == 1 || m_st[i] == 2) && s >= 1 && s <= 10;
    return pk(s, m_st[i] == 1, m_st[i] == 3, m_to[i], w);
  endfunction

  function automatic logic [19:0] dut_out(input int i);
    return {sec_o[i], tens_o[i], ones_o[i], run_o[i], exp_o[i], to_o[i], warn_o[i]};
  endfunction

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (dut_out(i) !== model_out(i)) begin
          n_err++;
          $display("FAIL model[%0d] t=%0t: got %h expected %h", i, $time, dut_out(i), model_out(i));
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input bit s, input bit p, input bit a);
    @(negedge clk);
    start = s;
    pause = p;
    abort = a;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit s, p, a;
    int n;
    int sec;
    bit run, ex, to, w;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int  kto;
    bit  found;
    bit  ph;
    int  r;

    tbl[0]  = '{0, 0, 0, 1,  3, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 1,  3, 1, 0, 0, 1};
    tbl[2]  = '{0, 0, 0, 9,  3, 1, 0, 0, 1};
    tbl[3]  = '{0, 0, 0, 1,  2, 1, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 10, 1, 1, 0, 0, 1};
    tbl[5]  = '{0, 0, 0, 9,  1, 1, 0, 0, 1};
    tbl[6]  = '{0, 0, 0, 1,  0, 0, 1, 1, 0};
    tbl[7]  = '{0, 0, 0, 1,  0, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 5,  0, 0, 1, 0, 0};
    tbl[9]  = '{1, 0, 0, 1,  3, 1, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 4,  3, 1, 0, 0, 1};
    tbl[11] = '{0, 1, 0, 3,  3, 0, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 1,  3, 1, 0, 0, 1};
    tbl[13] = '{0, 0, 0, 4,  3, 1, 0, 0, 1};
    tbl[14] = '{0, 0, 0, 1,  2, 1, 0, 0, 1};
    tbl[15] = '{0, 0, 1, 1,  3, 0, 0, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_a", dut_out(0), pk(3, 0, 0, 0, 0));
    chk("reset_b", dut_out(1), pk(11, 0, 0, 0, 0));
    chk("reset_c", dut_out(2), pk(12, 0, 0, 0, 0));
    chk_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < tbl[i].n; j++) step(tbl[i].s, tbl[i].p, tbl[i].a);
      chk($sformatf("vec%0d", i), dut_out(0),
          pk(tbl[i].sec, tbl[i].run, tbl[i].ex, tbl[i].to, tbl[i].w));
    end

    // Seven paused cycles in the middle of a second stretch the 30-cycle round to 37
    step(1, 0, 0);
    found = 1'b0;
    kto   = -1;
    for (int k = 1; k <= 60 && !found; k++) begin
      step(0, (k >= 15 && k <= 21), 0);
      if (k == 21) chk("pause_frozen", sec_o[0], 2);
      if (to_o[0]) begin
        found = 1'b1;
        kto   = k;
      end
    end
    chk("pause_timeout_cycle", kto, 37);
    step(0, 0, 0);
    chk("timeout_one_cycle", dut_out(0), pk(0, 0, 1, 0, 0));

    step(0, 0, 1);
    step(1, 0, 0);
    for (int k = 1; k <= 121; k++) begin
      step(0, 0, 0);
      if (k == 10)  chk("bcd_ten", dut_out(1), pk(10, 1, 0, 0, 1));
      if (k == 20)  chk("bcd_borrow", dut_out(1), pk(9, 1, 0, 0, 1));
      if (k == 19)  chk("warn_pre", dut_out(2), pk(11, 1, 0, 0, 0));
      if (k == 20)  chk("warn_rise", dut_out(2), pk(10, 1, 0, 0, 1));
      if (k == 119) chk("warn_last", dut_out(2), pk(1, 1, 0, 0, 1));
      if (k == 120) chk("warn_expire", dut_out(2), pk(0, 0, 1, 1, 0));
    end

    step(0, 0, 1);
    step(1, 0, 0);
    repeat (25) step(0, 0, 0);
    chk("at_one_sec", sec_o[0], 1);
    step(0, 0, 1);
    chk("abort_at_1", dut_out(0), pk(3, 0, 0, 0, 0));
    repeat (15) step(0, 0, 0);
    chk("abort_no_timeout", dut_out(0), pk(3, 0, 0, 0, 0));

    step(1, 0, 0);
    repeat (9) step(0, 0, 0);
    step(1, 0, 0);
    chk("start_on_wrap", dut_out(0), pk(3, 1, 0, 0, 1));
    repeat (9) step(0, 0, 0);
    chk("restart_hold", dut_out(0), pk(3, 1, 0, 0, 1));
    step(0, 0, 0);
    chk("restart_dec", dut_out(0), pk(2, 1, 0, 0, 1));

    repeat (5) step(0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midround_reset_a", dut_out(0), pk(3, 0, 0, 0, 0));
    chk("midround_reset_c", dut_out(2), pk(12, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    ph = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 199);
      if ($urandom_range(0, 19) == 0) ph = ~ph;
      step(r < 2, ph, r == 199);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
